log_req_arbiter: RTL

//  Shares one thv_top hyperbolic-CORDIC log2 engine between NUM_REQ requesters. Only one

---
 rtl/log_ctrl_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 30 +++
 rtl/log_req_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/log_ctrl_pkg.sv
// Shared types and constants for the log2-engine request arbiter.
// Includes the field layout of IEEE-754 singles and the screening classifier.
package log_ctrl_pkg;

  localparam int LOG_W       = 33;
  localparam int FP_W        = 32;
  localparam int EXP_MSB     = 30;
  localparam int EXP_LSB     = 23;
  localparam int LOG_INT_LSB = 25;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [2:0] ERR_OK      = 3'd0;
  localparam logic [2:0] ERR_NEG     = 3'd1;
  localparam logic [2:0] ERR_ZERO    = 3'd2;
  localparam logic [2:0] ERR_INFNAN  = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

  // Priority order matters: -0 and -NaN must report ZERO / INFNAN, not NEG.
  function automatic logic [2:0] classify_fp(input logic [FP_W-1:0] fp);
    logic [EXP_MSB-EXP_LSB:0] e;
    e = fp[EXP_MSB:EXP_LSB];
    if (e == '1) begin
      return ERR_INFNAN;
    end else if (e == '0) begin
      return ERR_ZERO;
    end else if (fp[FP_W-1]) begin
      return ERR_NEG;
    end
    return ERR_OK;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the pointer,
// wrapping modulo NUM_REQ. Returns the one-hot grant and its index.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PW-1:0]      o_idx,
  output logic               o_any
);

  always_comb begin
    logic [PW-1:0] j;
    j       = '0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = PW'((32'(i_ptr) + k) % NUM_REQ);
      if (!o_any && i_req[j]) begin
        o_any      = 1'b1;
        o_idx      = j;
        o_grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/log_req_arbiter.sv
// Shares one log2 engine among NUM_REQ requesters: round-robin accept, input screening,
// engine sequencing with timeout, and response return to the owning requester.
module log_req_arbiter
  import log_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [FP_W*NUM_REQ-1:0] req_fp_value,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [LOG_W-1:0]        rsp_log_value,
  output logic [2:0]              rsp_err,
  output logic                    busy,
  output logic                    eng_start,
  output logic [FP_W-1:0]         eng_fp_value,
  input  logic [LOG_W-1:0]        eng_log_value,
  input  logic                    eng_valid
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e             r_state, w_state_d;
  logic [PW-1:0]      r_ptr, w_ptr_d;
  logic [PW-1:0]      r_owner, w_owner_d;
  logic [CW-1:0]      r_cnt, w_cnt_d;
  logic [FP_W-1:0]    r_fp, w_fp_d;
  logic [LOG_W-1:0]   r_log, w_log_d;
  logic [2:0]         r_err, w_err_d;

  logic [NUM_REQ-1:0] w_grant;
  logic [PW-1:0]      w_idx;
  logic               w_any;
  logic [FP_W-1:0]    w_sel_fp;
  logic [2:0]         w_cls;
  logic [CW-1:0]      w_cnt_inc;
  logic [PW-1:0]      w_ptr_inc;
  logic [NUM_REQ-1:0] w_owner_oh;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Screening on the incoming word is equivalent to screening the latched copy and
  // lets a rejected request reach RESP one cycle after accept.
  assign w_sel_fp  = req_fp_value[32'(w_idx)*FP_W +: FP_W];
  assign w_cls     = classify_fp(w_sel_fp);
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_ptr_inc = PW'((32'(w_idx) + 32'd1) % NUM_REQ);

  always_comb begin
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    w_owner_d = r_owner;
    w_cnt_d   = r_cnt;
    w_fp_d    = r_fp;
    w_log_d   = r_log;
    w_err_d   = r_err;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_owner_d = w_idx;
          w_ptr_d   = w_ptr_inc;
          if (w_cls == ERR_OK) begin
            w_fp_d    = w_sel_fp;
            w_state_d = ISSUE;
          end else begin
            w_log_d   = '0;
            w_err_d   = w_cls;
            w_state_d = RESP;
          end
        end
      end
      ISSUE: begin
        w_cnt_d   = '0;
        w_state_d = WAIT;
      end
      WAIT: begin
        w_cnt_d = w_cnt_inc;
        if (eng_valid) begin
          w_log_d   = eng_log_value;
          w_err_d   = ERR_OK;
          w_state_d = RESP;
        end else if (w_cnt_inc == CW'(TIMEOUT - 1)) begin
          w_log_d   = '0;
          w_err_d   = ERR_TIMEOUT;
          w_state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[r_owner]) begin
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
      r_fp    <= '0;
      r_log   <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
      r_owner <= w_owner_d;
      r_cnt   <= w_cnt_d;
      r_fp    <= w_fp_d;
      r_log   <= w_log_d;
      r_err   <= w_err_d;
    end
  end

  always_comb begin
    w_owner_oh          = '0;
    w_owner_oh[r_owner] = 1'b1;
  end

  assign req_ready     = (r_state == IDLE) ? w_grant : '0;
  assign rsp_valid     = (r_state == RESP) ? w_owner_oh : '0;
  assign rsp_log_value = r_log;
  assign rsp_err       = r_err;
  assign busy          = (r_state != IDLE);
  assign eng_start     = (r_state == ISSUE);
  assign eng_fp_value  = r_fp;

endmodule
